bus_cycle_sequencer: RTL
========================

// Module: bus_cycle_sequencer
// PURPOSE
//  Sequences every external memory access of the 6502 core over the 8-bit TT pins.
//  Takes one 16-bit address/data request from the core per transaction and multiplexes
//  the address over uo_out as low byte, then high byte.
//  Runs the data phase on uio with wait states and a bus turnaround cycle.
//  Returns read data / completion to the core on a 1-cycle response strobe.
// PARAMETERS
//  WAIT_MAX     15  max extra DATA cycles while bus_rdy=0 before timeout (>=1)
//  TURN_CYCLES  1   uio_oe=0 idle cycles after every write before next request (>=1)
// PORTS
//  clk_output  in   1   sequencer clock (CPU output clock domain)
//  rst_n       in   1   synchronous active-low reset
//  req_valid   in   1   core requests a bus cycle
//  req_ready   out  1   sequencer accepts request this cycle (high only in IDLE)
//  req_rw      in   1   0=read, 1=write (same RW sense as data_flags[0])
//  req_addr    in   16  transaction address
//  req_wdata   in   8   write data
//  resp_valid  out  1   1-cycle pulse: transaction complete
//  resp_rdata  out  8   read data, valid with resp_valid (0 for writes/timeouts)
//  resp_err    out  1   valid with resp_valid: 1 = wait-state timeout
//  bus_rdy     in   1   external device ready; sampled only in DATA
//  addr_out    out  8   multiplexed address byte (drives uo_out)
//  addr_hi     out  1   1 when addr_out carries the high byte
//  bus_active  out  1   1 in ALO/AHI/DATA
//  uio_in      in   8   external data in
//  uio_out     out  8   external data out
//  uio_oe      out  8   8'hFF while driving write data, else 8'h00
// BEHAVIOUR
//  All outputs are registered.
//  Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0,
//   addr_out=0, addr_hi=0, bus_active=0, uio_out=0, uio_oe=0, wait cnt=0.
//  States: IDLE -> ALO -> AHI -> DATA -> (write: TURN) -> IDLE.
//  IDLE: req_ready=1.
//   - req_valid=1 captures rw/addr/wdata and moves to ALO.
//   - addr_out holds its last value.
//  ALO (1 cyc): addr_out=addr[7:0], addr_hi=0.
//  AHI (1 cyc): addr_out=addr[15:8], addr_hi=1.
//  DATA, general: addr_out/addr_hi hold the AHI values.
//   - Write: uio_oe=8'hFF, uio_out=wdata.
//   - Read: uio_oe=0.
//  DATA, cycle exit (wait cnt starts at 0):
//   - bus_rdy=1: complete. Read latches uio_in into resp_rdata; resp_valid=1 and
//     resp_err=0 on the following cycle.
//   - bus_rdy=0 and cnt<WAIT_MAX: cnt++, stay in DATA.
//   - bus_rdy=0 and cnt==WAIT_MAX: timeout; resp_valid=1, resp_err=1, resp_rdata=0.
//   - DATA therefore lasts at most WAIT_MAX+1 cycles.
//  DATA exit target: read -> IDLE; write -> TURN.
//  TURN: uio_oe=0 for TURN_CYCLES, req_ready=0, then IDLE. Applies after timeouts too.
//  Latency: request accepted at edge N -> resp_valid high in cycle N+4 (zero waits).
//   - Back-to-back reads: 1 per 4 cycles.
//   - Back-to-back writes: 1 per 4+TURN_CYCLES cycles.
//  resp_valid has no backpressure; the core must take it.
//   - The resp_valid cycle is in IDLE or TURN, never overlapping the next ALO.
//  Request inputs are ignored outside IDLE.
//   - Captured values stay frozen even if req_* change mid-transaction.
//  uio_oe is never 8'hFF outside DATA of a write. It drops to 0 at the edge leaving DATA.
//  Reset mid-transaction: next edge forces all reset values.
//   - uio_oe=0 immediately; the aborted transaction produces no resp_valid.
// TESTING
//  Read 0x1234, bus_rdy=1, uio_in=8'hA5:
//   -> addr_out 0x34 (addr_hi=0), then 0x12 (addr_hi=1); 1 DATA cycle;
//      resp_valid with rdata=A5, err=0 at N+4.
//  Write 0xBEEF with 8'h5A:
//   -> uio_oe=FF and uio_out=5A only in the single DATA cycle; 1 TURN cycle with oe=0;
//      req_ready low from ALO through TURN.
//  Read with bus_rdy low for 3 DATA cycles, uio_in=8'h3C:
//   -> DATA lasts 4 cycles; resp_valid at N+7 with rdata=3C.
//  bus_rdy held 0, WAIT_MAX=15:
//   -> DATA lasts 16 cycles; resp_valid=1, resp_err=1, rdata=0; write case also takes TURN.
//  rst_n=0 during write DATA:
//   -> next cycle uio_oe=0, state IDLE, req_ready=1; no resp_valid ever for that write.
//  req_valid held high, reads at 0x0001/0x0002/0x0003:
//   -> accepts every 4 cycles; responses in order with matching rdata.

Source files
------------

// File: rtl/bus_cycle_sequencer_if.sv
// Core request/response and 8-bit TT pin bus bundle for the 6502 bus cycle sequencer.
// The master modport is the core plus external-device side; the slave modport is the sequencer.
interface bus_cycle_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        resp_valid;
  logic [7:0]  resp_rdata;
  logic        resp_err;
  logic        bus_rdy;
  logic [7:0]  addr_out;
  logic        addr_hi;
  logic        bus_active;
  logic [7:0]  uio_in;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;

  modport master (
    output req_valid, req_rw, req_addr, req_wdata, bus_rdy, uio_in,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           addr_out, addr_hi, bus_active, uio_out, uio_oe
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata, bus_rdy, uio_in,
    output req_ready, resp_valid, resp_rdata, resp_err,
           addr_out, addr_hi, bus_active, uio_out, uio_oe
  );
endinterface

// File: rtl/bus_cycle_sequencer.sv
// Muxes a 16-bit core access onto 8 pins: addr lo, addr hi, data (wait states), turnaround after writes.
// Response 4 cycles after accept with zero waits; req_ready only in IDLE, resp_valid has no backpressure.
module bus_cycle_sequencer #(
  parameter int WAIT_MAX    = 15,
  parameter int TURN_CYCLES = 1
) (
  input  logic                  clk_output,
  input  logic                  rst_n,
  bus_cycle_sequencer_if.slave  bus
);

  localparam int WCW = (WAIT_MAX    < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam int TCW = (TURN_CYCLES < 2) ? 1 : $clog2(TURN_CYCLES);
  localparam logic [WCW-1:0] WAIT_LIM = WCW'(WAIT_MAX);
  localparam logic [TCW-1:0] TURN_LIM = TCW'(TURN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALO,
    S_AHI,
    S_DATA,
    S_TURN
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_rw;
  logic [15:0]    r_addr;
  logic [7:0]     r_wdata;
  logic [WCW-1:0] r_wait_cnt;
  logic [TCW-1:0] r_turn_cnt;

  logic           r_req_ready;
  logic           r_resp_valid;
  logic [7:0]     r_resp_rdata;
  logic           r_resp_err;
  logic [7:0]     r_addr_out;
  logic           r_addr_hi;
  logic           r_bus_active;
  logic [7:0]     r_uio_out;
  logic [7:0]     r_uio_oe;

  logic           w_accept;
  logic           w_done;
  logic           w_timeout;

  assign w_accept  = (r_state == S_IDLE) && bus.req_valid;
  assign w_done    = (r_state == S_DATA) && bus.bus_rdy;
  assign w_timeout = (r_state == S_DATA) && !bus.bus_rdy && (r_wait_cnt == WAIT_LIM);

  always_ff @(posedge clk_output) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.req_valid) w_state_nxt = S_ALO;
      S_ALO:   w_state_nxt = S_AHI;
      S_AHI:   w_state_nxt = S_DATA;
      S_DATA:  if (w_done || w_timeout) w_state_nxt = r_rw ? S_TURN : S_IDLE;
      S_TURN:  if (r_turn_cnt == TURN_LIM) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Every output is computed from the next state so the pins change on the same edge as the state.
  always_ff @(posedge clk_output) begin
    if (!rst_n) begin
      r_rw         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wait_cnt   <= '0;
      r_turn_cnt   <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_addr_out   <= '0;
      r_addr_hi    <= 1'b0;
      r_bus_active <= 1'b0;
      r_uio_out    <= '0;
      r_uio_oe     <= '0;
    end else begin
      if (w_accept) begin
        r_rw    <= bus.req_rw;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
      end

      if (r_state == S_DATA && !bus.bus_rdy && !w_timeout) r_wait_cnt <= r_wait_cnt + WCW'(1);
      else                                                   r_wait_cnt <= '0;

      if (r_state == S_TURN) r_turn_cnt <= r_turn_cnt + TCW'(1);
      else                   r_turn_cnt <= '0;

      r_req_ready  <= (w_state_nxt == S_IDLE);
      r_bus_active <= (w_state_nxt == S_ALO) || (w_state_nxt == S_AHI) || (w_state_nxt == S_DATA);

      if (w_accept) begin
        r_addr_out <= bus.req_addr[7:0];
        r_addr_hi  <= 1'b0;
      end else if (r_state == S_ALO) begin
        r_addr_out <= r_addr[15:8];
        r_addr_hi  <= 1'b1;
      end

      if (w_state_nxt == S_DATA && r_rw) begin
        r_uio_oe  <= 8'hFF;
        r_uio_out <= r_wdata;
      end else begin
        r_uio_oe  <= 8'h00;
      end

      r_resp_valid <= w_done || w_timeout;
      if (w_done || w_timeout) begin
        r_resp_err   <= w_timeout;
        r_resp_rdata <= (w_done && !r_rw) ? bus.uio_in : 8'h00;
      end
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign bus.addr_out   = r_addr_out;
  assign bus.addr_hi    = r_addr_hi;
  assign bus.bus_active = r_bus_active;
  assign bus.uio_out    = r_uio_out;
  assign bus.uio_oe     = r_uio_oe;

endmodule
